// File: rtl/n64_joybus_pkg.sv
// Shared definitions for the N64 Joybus host: FSM state encoding, command
// byte constants, microsecond phase multipliers and the reply-length clamp.
package n64_joybus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LOW,
    ST_TX_HIGH,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_RX_SAMPLE,
    ST_RX_END,
    ST_FINISH
  } state_t;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  // Phase lengths in microseconds
  localparam int unsigned TX_LONG_US  = 3;
  localparam int unsigned TX_SHORT_US = 1;
  localparam int unsigned SAMPLE_US   = 2;
  localparam int unsigned STOP_US     = 1;

  localparam int unsigned MAX_RX_BYTES = 4;

  // Reply lengths above four bytes behave as four
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
    return (n > 3'(MAX_RX_BYTES)) ? 3'(MAX_RX_BYTES) : n;
  endfunction

endpackage

// File: rtl/n64_line_sampler.sv
// Controller line conditioning: 2-flop synchroniser, optional 3-sample
// glitch filter, and registered falling-edge detect.
// Ports: clk, rst (sync, active high), data_in (async raw line),
//        line (conditioned level), fall (one-cycle falling-edge pulse).
// Macro N64_HOST_GLITCH_FILTER_EN enables the glitch filter (+2 cycles).
module n64_line_sampler (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic line,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic level_c;
  logic level_prev;

  // Synchroniser; idle line is high (pull-up)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
    end
  end

`ifdef N64_HOST_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;
  logic level_q;

  // Accept a new level only once three consecutive samples agree
  always_ff @(posedge clk) begin
    if (rst) begin
      hist1   <= 1'b1;
      hist2   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      hist1   <= sync2;
      hist2   <= hist1;
      level_q <= level_c;
    end
  end

  assign level_c = ((sync2 == hist1) && (hist1 == hist2)) ? sync2 : level_q;
`else
  assign level_c = sync2;
`endif

  assign line = level_c;

  // Falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev <= 1'b1;
      fall       <= 1'b0;
    end else begin
      level_prev <= level_c;
      fall       <= level_prev & ~level_c;
    end
  end

endmodule

// File: rtl/n64_joybus_host.sv
// Console-side Joybus initiator: sends one command byte on the open-drain
// controller line, then decodes a 0-4 byte reply into RSP_DATA.
// Parameters: CLKS_PER_US (fabric cycles per us, >= 4), TIMEOUT_US.
// Ports: FAB_CLK, RESET (sync, active high), START/CMD/RX_NBYTES request,
//        DATA_IN raw line, DATA_OE (1 = pull low), BUSY, DONE/TIMEOUT pulses,
//        RSP_DATA (right-aligned reply), RSP_VALID.
// Macro N64_HOST_GLITCH_FILTER_EN (in n64_line_sampler) filters short glitches.
module n64_joybus_host
  import n64_joybus_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 100,
  parameter int unsigned TIMEOUT_US  = 100
) (
  input  logic        FAB_CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  CMD,
  input  logic [2:0]  RX_NBYTES,
  input  logic        DATA_IN,
  output logic        DATA_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [31:0] RSP_DATA,
  output logic        RSP_VALID
);

  localparam int unsigned TO_CYCLES   = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned LONG_CYCLES = TX_LONG_US * CLKS_PER_US;
  localparam int unsigned CNT_MAX     = (TO_CYCLES > LONG_CYCLES) ? TO_CYCLES : LONG_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(TX_SHORT_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_US * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TO_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [2:0]       nbytes_q, nbytes_d;
  logic [5:0]       rx_bits_q, rx_bits_d;
  logic             seen_q, seen_d;
  logic [31:0]      rsp_data_d;
  logic             rsp_valid_d;
  logic             timeout_d;
  logic             done_d;
  logic             busy_d;
  logic             oe_d;
  logic             tx_bit_c;
  logic             line;
  logic             fall;

  n64_line_sampler u_sampler (
    .clk     (FAB_CLK),
    .rst     (RESET),
    .data_in (DATA_IN),
    .line    (line),
    .fall    (fall)
  );

  // State and output registers
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      cmd_q     <= '0;
      nbytes_q  <= '0;
      rx_bits_q <= '0;
      seen_q    <= 1'b0;
      DATA_OE   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      TIMEOUT   <= 1'b0;
      RSP_DATA  <= '0;
      RSP_VALID <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
      nbytes_q  <= nbytes_d;
      rx_bits_q <= rx_bits_d;
      seen_q    <= seen_d;
      DATA_OE   <= oe_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      TIMEOUT   <= timeout_d;
      RSP_DATA  <= rsp_data_d;
      RSP_VALID <= rsp_valid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    cmd_d       = cmd_q;
    nbytes_d    = nbytes_q;
    rx_bits_d   = rx_bits_q;
    seen_d      = seen_q;
    rsp_data_d  = RSP_DATA;
    rsp_valid_d = RSP_VALID;
    timeout_d   = 1'b0;
    tx_bit_c    = cmd_q[bit_q];

    unique case (state_q)
      ST_IDLE: begin
        // The cycle carrying a TIMEOUT pulse still counts as the end of the
        // previous transaction, so START is not accepted in it.
        if (START && !TIMEOUT) begin
          state_d     = ST_TX_LOW;
          cmd_d       = CMD;
          nbytes_d    = clamp_nbytes(RX_NBYTES);
          bit_d       = 3'd7;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b0;
        end
      end
      ST_TX_LOW: begin
        if (cnt_q == (tx_bit_c ? SHORT_LAST : LONG_LAST)) begin
          state_d = ST_TX_HIGH;
        end
      end
      ST_TX_HIGH: begin
        if (cnt_q == (tx_bit_c ? LONG_LAST : SHORT_LAST)) begin
          if (bit_q == 3'd0) begin
            state_d = ST_TX_STOP;
          end else begin
            bit_d   = bit_q - 3'd1;
            state_d = ST_TX_LOW;
          end
        end
      end
      ST_TX_STOP: begin
        if (cnt_q == STOP_LAST) begin
          rx_bits_d = '0;
          seen_d    = 1'b0;
          state_d   = (nbytes_q == 3'd0) ? ST_FINISH : ST_RX_WAIT;
        end
      end
      ST_RX_WAIT: begin
        if (fall) begin
          state_d = ST_RX_SAMPLE;
        end else if (cnt_q == TO_LAST) begin
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_RX_SAMPLE: begin
        // Sample mid-bit: a '1' has returned high by now, a '0' is still low
        if (cnt_q == SAMPLE_LAST) begin
          rsp_data_d = {RSP_DATA[30:0], line};
          rx_bits_d  = rx_bits_q + 1'b1;
          state_d    = (rx_bits_d == {nbytes_q, 3'b000}) ? ST_RX_END : ST_RX_WAIT;
        end
      end
      ST_RX_END: begin
        // Stop bit: a falling edge followed by the line returning high
        if (seen_q && line) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_FINISH;
        end else if (cnt_q == TO_LAST) begin
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (fall) begin
          seen_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state times itself from its own entry
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // FINISH is the DONE cycle, already outside the busy window
    oe_d   = (state_d == ST_TX_LOW) || (state_d == ST_TX_STOP);
    done_d = (state_d == ST_FINISH);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
  end

endmodule

// File: tb/tb_n64_joybus_host.sv
`timescale 1ns/1ps
module tb_n64_joybus_host;
  import n64_joybus_pkg::*;

  localparam int unsigned CPU   = 4;
  localparam int unsigned TO_US = 100;

  localparam int M_OK     = 0;
  localparam int M_SILENT = 1;
  localparam int M_STUCK  = 2;
  localparam int M_GLITCH = 3;

  typedef struct packed {
    logic        is_to;
    logic        valid;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cmd;
  logic [2:0]  nbytes;
  logic        ctrl_low;
  logic        data_line;
  logic        data_oe;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] rsp_data;
  logic        rsp_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  // Open-drain wired-AND of host and controller
  assign data_line = ~(data_oe | ctrl_low);

  n64_joybus_host #(.CLKS_PER_US(CPU), .TIMEOUT_US(TO_US)) dut (
    .FAB_CLK   (clk),
    .RESET     (rst),
    .START     (start),
    .CMD       (cmd),
    .RX_NBYTES (nbytes),
    .DATA_IN   (data_line),
    .DATA_OE   (data_oe),
    .BUSY      (busy),
    .DONE      (done),
    .TIMEOUT   (timeout),
    .RSP_DATA  (rsp_data),
    .RSP_VALID (rsp_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every DONE/TIMEOUT pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done || timeout) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, done, timeout}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("end_kind", {30'b0, done, timeout}, mon_e.is_to ? 32'h1 : 32'h2);
        check("busy_at_end", {31'b0, busy}, 32'h0);
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, mon_e.valid});
        if (!mon_e.is_to) check("rsp_data", rsp_data, mon_e.data);
      end
    end
  end

  task automatic send_bit(input logic b);
    ctrl_low = 1'b1;
    repeat (b ? CPU : 3 * CPU) @(negedge clk);
    ctrl_low = 1'b0;
    repeat (b ? 3 * CPU : CPU) @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [2:0] n, input logic [31:0] reply,
                         input int mode, input int stuck_byte);
    int          nb, len, hi, terr, stop_len, w, lo;
    int unsigned t_oe, t_rel, dt;
    logic [7:0]  got;
    logic [31:0] mask;
    exp_t        x;

    nb   = (n > 3'd4) ? 4 : int'(n);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    x.is_to = (nb != 0) && (mode == M_SILENT || mode == M_STUCK);
    x.valid = (nb != 0) && !x.is_to;
    x.data  = (nb == 0) ? 32'h0 : (reply & mask);
    sb_q.push_back(x);

    @(posedge clk); #1;
    start = 1'b1; cmd = c; nbytes = n;
    @(posedge clk); #1;
    start = 1'b0; cmd = 8'($urandom); nbytes = 3'($urandom);

    @(negedge clk);
    check("oe_after_start", {31'b0, data_oe}, 32'h1);
    check("busy_after_start", {31'b0, busy}, 32'h1);
    t_oe = cyc;

    // Decode the command from DATA_OE low/high phase lengths
    got = '0; terr = 0;
    for (int b = 7; b >= 0; b--) begin
      len = 0;
      while (data_oe && len < 100) begin
        len++;
        if (b == 7 && len == 2) begin
          start = 1'b1; cmd = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      start = 1'b0;
      hi = 0;
      while (!data_oe && hi < 100) begin
        hi++;
        @(negedge clk);
      end
      got[b] = (len < 2 * CPU);
      if (!((len == CPU && hi == 3 * CPU) || (len == 3 * CPU && hi == CPU))) terr++;
    end
    stop_len = 0;
    while (data_oe && stop_len < 100) begin
      stop_len++;
      @(negedge clk);
    end
    t_rel = cyc;
    check("tx_cmd", {24'b0, got}, {24'b0, c});
    check("tx_timing_errs", terr, 0);
    check("tx_stop_len", stop_len, CPU);

    // Controller side of the exchange
    if (nb != 0) begin
      if (mode == M_OK || mode == M_GLITCH) begin
        repeat (2 * CPU) @(negedge clk);
        if (mode == M_GLITCH) begin
          ctrl_low = 1'b1;
          @(negedge clk);
          ctrl_low = 1'b0;
          repeat (2 * CPU) @(negedge clk);
        end
        for (int i = 8 * nb - 1; i >= 0; i--) send_bit(reply[i]);
        ctrl_low = 1'b1;
        repeat (2 * CPU) @(negedge clk);
        ctrl_low = 1'b0;
      end else if (mode == M_STUCK) begin
        repeat (2 * CPU) @(negedge clk);
        lo = 8 * nb - 8 * stuck_byte;
        for (int i = 8 * nb - 1; i >= lo; i--) send_bit(reply[i]);
        ctrl_low = 1'b1;
      end
    end

    w = 0;
    while (busy && w < 3000) begin
      w++;
      @(negedge clk);
    end
    check("busy_drops", {31'b0, busy}, 32'h0);
    if (nb == 0) check("done_latency", cyc - t_oe, 32'd132);
    if (mode == M_SILENT && nb != 0) begin
      dt = cyc - t_rel;
      check("timeout_latency_in_range", {31'b0, (dt >= 396 && dt <= 404)}, 32'h1);
    end

    // START in the DONE/TIMEOUT cycle must be ignored
    start = 1'b1; cmd = c;
    @(negedge clk);
    start = 1'b0;
    check("start_in_end_cycle_ignored", {31'b0, busy}, 32'h0);
    ctrl_low = 1'b0;
    repeat (4) @(negedge clk);
    if (!x.is_to) check("rsp_hold", rsp_data, x.data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_r, m_r;
    logic [2:0]  nr;
    logic [31:0] rr;

    rst = 1'b1; start = 1'b0; cmd = '0; nbytes = '0; ctrl_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe", {31'b0, data_oe}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done_timeout", {30'b0, done, timeout}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(CMD_POLL, 3'd0, 32'h0, M_OK, 0);
    run_txn(CMD_POLL, 3'd4, 32'h8000_7F80, M_OK, 0);
    run_txn(CMD_INFO, 3'd3, 32'h0005_0002, M_OK, 0);
    run_txn(CMD_POLL, 3'd1, 32'h0, M_SILENT, 0);
    run_txn(CMD_POLL, 3'd4, $urandom, M_STUCK, 2);

    // Reset in the middle of the first low phase
    @(posedge clk); #1;
    start = 1'b1; cmd = CMD_POLL; nbytes = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("oe_before_reset", {31'b0, data_oe}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("oe_after_reset", {31'b0, data_oe}, 32'h0);
    check("busy_after_reset", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    run_txn(CMD_RESET, 3'd3, $urandom, M_OK, 0);

    run_txn(8'hA5, 3'd6, $urandom, M_OK, 0);
`ifdef N64_HOST_GLITCH_FILTER_EN
    run_txn(CMD_POLL, 3'd2, $urandom, M_GLITCH, 0);
`endif

    for (int k = 0; k < 8; k++) begin
      nr  = 3'($urandom_range(0, 7));
      rr  = $urandom;
      n_r = $urandom_range(0, 3);
      m_r = (n_r == 0) ? M_SILENT : M_OK;
      run_txn(8'($urandom), nr, rr, m_r, 0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_joybus_host.md
# n64_joybus_host

Console-side Joybus initiator for the N64 controller fabric logic, clocked from the MSS CCC fabric clock. On a START strobe it serialises one command byte onto the open-drain controller data line, then releases the line and decodes the controller's 1–4 byte reply into a parallel word for the MSS/APB side. It is the transmitter for the controller's command receiver and the receiver for its reply.

## Interface
- CLKS_PER_US, default 100 — FAB_CLK cycles per microsecond (integer ≥ 4)
- TIMEOUT_US, default 100 — maximum wait for a controller falling edge
- FAB_CLK  in  1  fabric clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle request; honoured only while BUSY=0
- CMD  in  8  command byte, sent MSB first
- RX_NBYTES  in  3  reply length in bytes, 1–4; 0 means no reply expected; values >4 treated as 4
- DATA_IN  in  1  raw controller line (asynchronous)
- DATA_OE  out  1  1 = drive line low; 0 = release (external pull-up)
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle pulse on successful completion
- TIMEOUT  out  1  one-cycle pulse on aborted reply
- RSP_DATA  out  32  reply bits, right-aligned, first received bit most significant
- RSP_VALID  out  1  RSP_DATA holds the reply of the last successful transaction

## Operation
- States: IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_SAMPLE, RX_END, and FINISH.
- IDLE: DATA_OE=0. START latches CMD and RX_NBYTES and clears RSP_DATA. It then enters TX_LOW with bit counter 7.
- TX bit '0': 3 µs low (TX_LOW), then 1 µs released (TX_HIGH).
- TX bit '1': 1 µs low, then 3 µs released.
- After bit 0 is sent: TX_STOP drives the line low for 1 µs, then releases it. If RX_NBYTES=0, go to FINISH; otherwise go to RX_WAIT.
- RX_WAIT: wait for a falling edge on the sampled line, then go to RX_SAMPLE. The timeout counter starts at entry to this state.
- RX_SAMPLE: wait 2 µs (2*CLKS_PER_US cycles) after the edge, then sample the line. High = 1, low = 0.
  - Shift the bit into RSP_DATA at bit 0; existing bits move left.
  - If 8*RX_NBYTES bits have been received, go to RX_END; otherwise go back to RX_WAIT.
- RX_END: wait for the controller stop bit: a falling edge, followed by the line returning high. Then go to FINISH.
- Timeout: in RX_WAIT or RX_END, if no required edge or line return arrives within TIMEOUT_US, do the following:
  - pulse TIMEOUT;
  - clear RSP_VALID;
  - return to IDLE.
- FINISH: pulse DONE; set RSP_VALID=1 if RX_NBYTES≠0, otherwise 0; return to IDLE.
- RSP_VALID is cleared at START.

## Timing
- Reset values: DATA_OE=0, BUSY=0, DONE=0, TIMEOUT=0, RSP_DATA=0, RSP_VALID=0. The internal sampled line resets to 1.
- RESET mid-transaction forces IDLE and DATA_OE=0 on the next edge, with no DONE or TIMEOUT pulse.
- DATA_OE rises in the cycle after START is sampled. BUSY rises in the same cycle.
- Each TX bit is exactly 4*CLKS_PER_US cycles. A full 8-bit TX plus stop is 33*CLKS_PER_US cycles.
- DONE and TIMEOUT are asserted in the same cycle that BUSY falls. A START in that cycle is ignored; START is accepted from the following cycle.
- START while BUSY=1 is ignored, and CMD changes have no effect.
- DATA_IN passes through a 2-flop synchroniser, giving 2 cycles of latency. Edge detection adds 1 cycle. All RX timing is measured from the detected edge.
- The host never drives the line during any RX state.
- RSP_DATA updates only in RX_SAMPLE and is stable from FINISH until the next START.

## Configuration
- N64_HOST_GLITCH_FILTER_EN defined: after the synchroniser, a line change is accepted only when 3 consecutive samples agree. This adds 2 cycles of latency and rejects pulses shorter than 3 cycles.
- Not defined: the synchroniser output is used directly, and pulses of 1 cycle are visible as edges.

## Structure
- Package n64_joybus_pkg holds:
  - the state enum;
  - command constants CMD_INFO=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF;
  - microsecond phase multipliers (3/1 for TX low/high, 2 for sample, 1 for stop).
- Sub-module n64_line_sampler contains the synchroniser, the optional glitch filter and the falling-edge detect. Outputs: line level and a one-cycle fall pulse.

## Test plan
- CLKS_PER_US=4, CMD=8'h01, RX_NBYTES=0 → DATA_OE low-phase pattern: seven low phases of 12 cycles, one of 4, then a 4-cycle stop; DONE exactly 132 cycles after DATA_OE rises; RSP_VALID=0.
- CMD=8'h01, RX_NBYTES=4, controller model replies 32'h8000_7F80 → DONE pulse, RSP_DATA=32'h8000_7F80, RSP_VALID=1.
- CMD=8'h00, RX_NBYTES=3, reply 24'h050002 → RSP_DATA=32'h0005_0002.
- No reply, TIMEOUT_US=100 → TIMEOUT pulse about 400 cycles after TX_STOP release; RSP_VALID=0, BUSY=0.
- Reply with the line held low permanently after byte 2 → TIMEOUT in RX_END or RX_WAIT; no DONE.
- RESET asserted mid TX_LOW → DATA_OE=0 and BUSY=0 next cycle; a START issued after reset runs normally.
- With N64_HOST_GLITCH_FILTER_EN, a 1-cycle low glitch during RX_WAIT → no bit is recorded.
